pb_int_sched: RTL and testbench

Priority scheduler sitting between the PicoBlaze interrupt request bank and the PicoBlaze core.
- Selects one pending masked source by fixed or round-robin priority.
- Raises the single CPU interrupt line, latches the winning vector for the ISR to read, and issues a one-cycle self-clearing `int_clear` pulse on acknowledge.
- Holds off further requests until the ISR signals end-of-interrupt.
- Includes an acknowledge watchdog that recovers from a lost ack.

---
 rtl/pb_int_sched_pkg.sv | 15 +
 rtl/pb_int_rr_arb.sv | 44 ++++
 rtl/pb_int_sched.sv | 132 +++++++++++++
 tb/tb_pb_int_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_int_sched_pkg.sv
// Shared FSM encoding and default parameter values for the PicoBlaze interrupt scheduler.
package pb_int_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int DEF_N_SRC       = 8;
  localparam int DEF_VEC_W       = 3;
  localparam int DEF_TO_W        = 8;
  localparam int DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/pb_int_rr_arb.sv
// Combinational rotating priority encoder: first set request at or above ptr, else lowest set request.
module pb_int_rr_arb
  import pb_int_sched_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int VEC_W = DEF_VEC_W
) (
  input  logic [N_SRC-1:0] req,
  input  logic [VEC_W-1:0] ptr,
  input  logic             mode,
  output logic [VEC_W-1:0] grant_idx,
  output logic             any
);

  logic [VEC_W-1:0] base;
  logic [N_SRC-1:0] upper_mask;
  logic [N_SRC-1:0] upper_req;
  logic [VEC_W-1:0] lo_idx;
  logic [VEC_W-1:0] hi_idx;

  // Fixed mode is just a rotation starting at index 0.
  assign base = mode ? ptr : '0;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_mask
      assign upper_mask[gi] = (VEC_W'(gi) >= base);
    end
  endgenerate

  assign upper_req = req & upper_mask;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req[k])       lo_idx = VEC_W'(k);
      if (upper_req[k]) hi_idx = VEC_W'(k);
    end
  end

  assign any       = |req;
  assign grant_idx = (|upper_req) ? hi_idx : lo_idx;

endmodule

// File: rtl/pb_int_sched.sv
// Interrupt scheduler between the PicoBlaze request bank and core: arbitrate, request, ack/clear, wait for EOI.
module pb_int_sched
  import pb_int_sched_pkg::*;
#(
  parameter int N_SRC       = DEF_N_SRC,
  parameter int VEC_W       = DEF_VEC_W,
  parameter int TO_W        = DEF_TO_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_SRC-1:0] pending_i,
  input  logic             prio_mode_i,
  input  logic             int_ack_i,
  input  logic             eoi_i,
  output logic             int_o,
  output logic [VEC_W-1:0] vector_o,
  output logic [N_SRC-1:0] int_clear_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [VEC_W-1:0] LAST_SRC = VEC_W'(N_SRC - 1);
  localparam bit               WDOG_EN  = (ACK_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             int_q, int_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [N_SRC-1:0] clear_q, clear_d;
  logic [N_SRC-1:0] vec_onehot;
  logic [VEC_W-1:0] grant_idx;
  logic             grant_any;

  pb_int_rr_arb #(
    .N_SRC (N_SRC),
    .VEC_W (VEC_W)
  ) u_arb (
    .req       (pending_i),
    .ptr       (rr_ptr_q),
    .mode      (prio_mode_i),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_onehot
      assign vec_onehot[gi] = (vector_q == VEC_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    vector_d  = vector_q;
    int_d     = int_q;
    busy_d    = busy_q;
    clear_d   = '0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d  = ST_REQ;
          vector_d = grant_idx;
          cnt_d    = '0;
          int_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        // A late ack still wins over an expiring watchdog in the same cycle.
        if (int_ack_i) begin
          state_d = ST_SERVICE;
          int_d   = 1'b0;
          clear_d = vec_onehot;
        end else if (WDOG_EN && (cnt_q == TO_LAST)) begin
          state_d   = ST_IDLE;
          int_d     = 1'b0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi_i) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = (vector_q == LAST_SRC) ? '0 : vector_q + VEC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      vector_q  <= '0;
      int_q     <= 1'b0;
      busy_q    <= 1'b0;
      clear_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      vector_q  <= vector_d;
      int_q     <= int_d;
      busy_q    <= busy_d;
      clear_q   <= clear_d;
      timeout_q <= timeout_d;
    end
  end

  assign int_o       = int_q;
  assign vector_o    = vector_q;
  assign int_clear_o = clear_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pb_int_sched.sv
// Self-checking bench for pb_int_sched: vector table, directed corner sequences, randomized run vs. model.
module tb_pb_int_sched;

  localparam int N   = 8;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pending = '0;
  logic       mode = 1'b0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       int_o;
  logic [2:0] vector_o;
  logic [7:0] int_clear_o;
  logic       busy_o;
  logic       timeout_o;

  int errs = 0;
  int checks = 0;

  // Reference model: phase 0 waiting for work, 1 CPU being asked, 2 ISR running.
  int m_phase, m_wait, m_ptr, m_vec;
  int e_int, e_clr, e_busy, e_to;

  pb_int_sched #(
    .N_SRC       (N),
    .VEC_W       (3),
    .TO_W        (8),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pending_i   (pending),
    .prio_mode_i (mode),
    .int_ack_i   (ack),
    .eoi_i       (eoi),
    .int_o       (int_o),
    .vector_o    (vector_o),
    .int_clear_o (int_clear_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pend;
    logic       md;
    logic       ak;
    logic       eo;
    logic       x_int;
    logic [2:0] x_vec;
    logic [7:0] x_clr;
    logic       x_busy;
    logic       x_to;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [7:0] p, input int base);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (base + k) % N;
      if (((p >> idx) & 8'd1) != 8'd0) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_ptr = 0; m_vec = 0;
    e_int = 0; e_clr = 0; e_busy = 0; e_to = 0;
  endtask

  task automatic model_step();
    e_clr = 0;
    e_to  = 0;
    case (m_phase)
      0: if (pending != 8'h00) begin
        m_vec = winner(pending, mode ? m_ptr : 0);
        m_phase = 1; m_wait = 0; e_int = 1; e_busy = 1;
      end
      1: begin
        m_wait++;
        if (ack) begin
          m_phase = 2; e_int = 0; e_clr = 1 << m_vec;
        end else if (TMO != 0 && m_wait == TMO) begin
          m_phase = 0; e_int = 0; e_busy = 0; e_to = 1;
        end
      end
      default: if (eoi) begin
        m_ptr = (m_vec + 1) % N;
        m_phase = 0; e_busy = 0;
      end
    endcase
  endtask

  task automatic check_model();
    chk("int_o", 32'(int_o), 32'(e_int));
    chk("vector_o", 32'(vector_o), 32'(m_vec));
    chk("int_clear_o", 32'(int_clear_o), 32'(e_clr));
    chk("busy_o", 32'(busy_o), 32'(e_busy));
    chk("timeout_o", 32'(timeout_o), 32'(e_to));
  endtask

  task automatic tick(input bit use_model);
    @(posedge clk);
    model_step();
    #1;
    if (use_model) check_model();
    $display("cyc t=%0t pend=%02h mode=%0d ack=%0d eoi=%0d -> int=%0d vec=%0d clr=%02h busy=%0d to=%0d",
             $time, pending, mode, ack, eoi, int_o, vector_o, int_clear_o, busy_o, timeout_o);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_int_o", 32'(int_o), 32'd0);
    chk("rst_vector_o", 32'(vector_o), 32'd0);
    chk("rst_int_clear_o", 32'(int_clear_o), 32'd0);
    chk("rst_busy_o", 32'(busy_o), 32'd0);
    chk("rst_timeout_o", 32'(timeout_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr [4];
    int n_int, n_to, n_clr;

    exp_rr = '{0, 7, 0, 7};
    //          pend  md  ak  eo   int vec  clr   busy to
    tbl[0]  = '{8'h28, 0, 0, 0,   1, 3, 8'h00, 1, 0};
    tbl[1]  = '{8'h28, 0, 1, 0,   0, 3, 8'h08, 1, 0};
    tbl[2]  = '{8'h20, 0, 0, 0,   0, 3, 8'h00, 1, 0};
    tbl[3]  = '{8'h20, 0, 0, 1,   0, 3, 8'h00, 0, 0};
    tbl[4]  = '{8'h20, 0, 0, 0,   1, 5, 8'h00, 1, 0};
    tbl[5]  = '{8'h20, 0, 1, 0,   0, 5, 8'h20, 1, 0};
    tbl[6]  = '{8'h00, 0, 0, 1,   0, 5, 8'h00, 0, 0};
    tbl[7]  = '{8'h00, 0, 0, 0,   0, 5, 8'h00, 0, 0};
    tbl[8]  = '{8'h00, 0, 1, 0,   0, 5, 8'h00, 0, 0};
    tbl[9]  = '{8'h01, 0, 0, 0,   1, 0, 8'h00, 1, 0};
    tbl[10] = '{8'h01, 0, 0, 1,   1, 0, 8'h00, 1, 0};
    tbl[11] = '{8'h01, 0, 1, 0,   0, 0, 8'h01, 1, 0};
    tbl[12] = '{8'h00, 0, 0, 1,   0, 0, 8'h00, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_int_o", 32'(int_o), 32'd0);
    chk("reset_vector_o", 32'(vector_o), 32'd0);
    chk("reset_busy_o", 32'(busy_o), 32'd0);
    chk("reset_clear_o", 32'(int_clear_o), 32'd0);
    chk("reset_timeout_o", 32'(timeout_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      pending = tbl[i].pend; mode = tbl[i].md; ack = tbl[i].ak; eoi = tbl[i].eo;
      tick(1'b0);
      chk($sformatf("tbl%0d_int", i), 32'(int_o), 32'(tbl[i].x_int));
      chk($sformatf("tbl%0d_vec", i), 32'(vector_o), 32'(tbl[i].x_vec));
      chk($sformatf("tbl%0d_clr", i), 32'(int_clear_o), 32'(tbl[i].x_clr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].x_busy));
      chk($sformatf("tbl%0d_to", i), 32'(timeout_o), 32'(tbl[i].x_to));
    end
    ack = 0; eoi = 0; pending = 0;

    // Round-robin fairness from a fresh pointer.
    do_reset();
    pending = 8'h81; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      chk("rr_vec", 32'(vector_o), 32'(exp_rr[i]));
      ack = 1; tick(1'b1); ack = 0;
      chk("rr_clr", 32'(int_clear_o), 32'(1 << exp_rr[i]));
      eoi = 1; tick(1'b1); eoi = 0;
    end

    // Watchdog: no ack for a full window.
    do_reset();
    pending = 8'h01; mode = 1'b0;
    n_int = 0; n_to = 0; n_clr = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      if (int_o) n_int++;
      if (timeout_o) n_to++;
      if (int_clear_o != 8'h00) n_clr++;
    end
    chk("wd_int_cycles", 32'(n_int), 32'd4);
    chk("wd_timeout_last", 32'(timeout_o), 32'd1);
    chk("wd_timeout_count", 32'(n_to), 32'd1);
    chk("wd_no_clear", 32'(n_clr), 32'd0);
    tick(1'b1);
    chk("wd_rerequest", 32'(int_o), 32'd1);

    // Ack on the cycle the watchdog would fire.
    repeat (3) tick(1'b1);
    ack = 1; tick(1'b1); ack = 0;
    chk("ack_final_to", 32'(timeout_o), 32'd0);
    chk("ack_final_clr", 32'(int_clear_o), 32'h01);

    // EOI with work still pending: one IDLE cycle before the next request.
    eoi = 1; tick(1'b1); eoi = 0;
    chk("b2b_e1_int", 32'(int_o), 32'd0);
    chk("b2b_e1_busy", 32'(busy_o), 32'd0);
    tick(1'b1);
    chk("b2b_e2_int", 32'(int_o), 32'd1);

    // Reset while in SERVICE.
    ack = 1; tick(1'b1); ack = 0;
    do_reset();
    pending = 8'h04; mode = 1'b0;
    tick(1'b1);
    chk("post_rst_int", 32'(int_o), 32'd1);
    chk("post_rst_vec", 32'(vector_o), 32'd2);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      pending = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      ack = ($urandom_range(0, 9) < 3);
      eoi = ($urandom_range(0, 9) < 3);
      tick(1'b1);
      if ($urandom_range(0, 63) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
